// File: rtl/vga_pattern_scheduler.sv
// Chooses which test pattern the VGA generator shows. Auto mode cycles through
// the patterns every HOLD_FRAMES frames; a manual request is applied at the next frame edge.
module vga_pattern_scheduler #(
  parameter int NUM_PATTERNS = 4,
  parameter int HOLD_FRAMES  = 60
) (
  input  logic       driver_clk,
  input  logic       sys_rst_n,
  input  logic       fsync_in,
  input  logic       sel_req,
  input  logic [2:0] sel_pattern,
  input  logic       resume,
  output logic       sel_ack,
  output logic [2:0] pattern_sel,
  output logic       pattern_update,
  output logic [7:0] frame_cnt,
  output logic       auto_mode,
  output logic       busy,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    SYNC_WAIT = 2'd0,
    AUTO      = 2'd1,
    PENDING   = 2'd2,
    MANUAL    = 2'd3
  } state_e;

  localparam logic [3:0] NP_W    = 4'(NUM_PATTERNS);
  localparam logic [2:0] NP_M1   = 3'(NUM_PATTERNS - 1);
  localparam logic [7:0] HOLD_M1 = 8'(HOLD_FRAMES - 1);

  state_e     state_q, state_d;
  logic       fsync_q, fsync_d;
  logic [2:0] pattern_sel_q, pattern_sel_d;
  logic [2:0] latched_q, latched_d;
  logic [7:0] frame_cnt_q, frame_cnt_d;
  logic       update_q, update_d;
  logic       ack_q, ack_d;
  logic       auto_q, auto_d;
  logic       busy_q, busy_d;

  logic       frame_edge;
  logic [2:0] req_clamped;
  logic [2:0] next_pattern;
  logic [7:0] cnt_sat_inc;

  // Request handshake: the requester raises sel_req with sel_pattern valid and
  // holds both until sel_ack; a request is taken only in AUTO or MANUAL, and
  // sel_ack pulses for exactly one cycle, the cycle after the request is latched.
  always_comb begin
    frame_edge   = fsync_q & ~fsync_in;
    req_clamped  = ({1'b0, sel_pattern} >= NP_W) ? NP_M1 : sel_pattern;
    next_pattern = (pattern_sel_q == NP_M1) ? 3'd0 : pattern_sel_q + 3'd1;
    cnt_sat_inc  = (frame_cnt_q == 8'hFF) ? frame_cnt_q : frame_cnt_q + 8'd1;

    state_d       = state_q;
    fsync_d       = fsync_in;
    pattern_sel_d = pattern_sel_q;
    latched_d     = latched_q;
    frame_cnt_d   = frame_cnt_q;
    update_d      = 1'b0;
    ack_d         = 1'b0;

    case (state_q)
      SYNC_WAIT: begin
        pattern_sel_d = 3'd0;
        if (frame_edge) begin
          state_d     = AUTO;
          frame_cnt_d = 8'd0;
        end
      end

      AUTO: begin
        if (frame_edge) begin
          if (frame_cnt_q >= HOLD_M1) begin
            frame_cnt_d   = 8'd0;
            pattern_sel_d = next_pattern;
            update_d      = 1'b1;
          end else begin
            frame_cnt_d = frame_cnt_q + 8'd1;
          end
        end
        // A request coinciding with a frame edge is only applied at the next edge.
        if (sel_req) begin
          latched_d = req_clamped;
          ack_d     = 1'b1;
          state_d   = PENDING;
        end
      end

      PENDING: begin
        if (frame_edge) begin
          pattern_sel_d = latched_q;
          update_d      = 1'b1;
          frame_cnt_d   = 8'd0;
          state_d       = MANUAL;
        end
      end

      MANUAL: begin
        if (frame_edge) begin
          frame_cnt_d = cnt_sat_inc;
        end
        // A new request takes priority over resume in the same cycle.
        if (sel_req) begin
          latched_d = req_clamped;
          ack_d     = 1'b1;
          state_d   = PENDING;
        end else if (resume) begin
          frame_cnt_d = 8'd0;
          state_d     = AUTO;
        end
      end

      default: begin
        state_d = SYNC_WAIT;
      end
    endcase

    auto_d = (state_d == SYNC_WAIT) || (state_d == AUTO);
    busy_d = (state_d == PENDING);
  end

  always_ff @(posedge driver_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q       <= SYNC_WAIT;
      fsync_q       <= 1'b1;
      pattern_sel_q <= 3'd0;
      latched_q     <= 3'd0;
      frame_cnt_q   <= 8'd0;
      update_q      <= 1'b0;
      ack_q         <= 1'b0;
      auto_q        <= 1'b1;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      fsync_q       <= fsync_d;
      pattern_sel_q <= pattern_sel_d;
      latched_q     <= latched_d;
      frame_cnt_q   <= frame_cnt_d;
      update_q      <= update_d;
      ack_q         <= ack_d;
      auto_q        <= auto_d;
      busy_q        <= busy_d;
    end
  end

  assign sel_ack        = ack_q;
  assign pattern_sel    = pattern_sel_q;
  assign pattern_update = update_q;
  assign frame_cnt      = frame_cnt_q;
  assign auto_mode      = auto_q;
  assign busy           = busy_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_vga_pattern_scheduler.sv
// Directed bench for vga_pattern_scheduler with HOLD_FRAMES=3, NUM_PATTERNS=4.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_vga_pattern_scheduler;

  localparam logic [1:0] ST_SYNC    = 2'd0;
  localparam logic [1:0] ST_AUTO    = 2'd1;
  localparam logic [1:0] ST_PENDING = 2'd2;
  localparam logic [1:0] ST_MANUAL  = 2'd3;

  logic       clk;
  logic       rst_n;
  logic       fsync_in;
  logic       sel_req;
  logic [2:0] sel_pattern;
  logic       resume;
  logic       sel_ack;
  logic [2:0] pattern_sel;
  logic       pattern_update;
  logic [7:0] frame_cnt;
  logic       auto_mode;
  logic       busy;
  logic [1:0] state_dbg;

  int n_cmp;
  int n_err;
  int upd_cnt;

  vga_pattern_scheduler #(
    .NUM_PATTERNS(4),
    .HOLD_FRAMES (3)
  ) dut (
    .driver_clk    (clk),
    .sys_rst_n     (rst_n),
    .fsync_in      (fsync_in),
    .sel_req       (sel_req),
    .sel_pattern   (sel_pattern),
    .resume        (resume),
    .sel_ack       (sel_ack),
    .pattern_sel   (pattern_sel),
    .pattern_update(pattern_update),
    .frame_cnt     (frame_cnt),
    .auto_mode     (auto_mode),
    .busy          (busy),
    .state_dbg     (state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (pattern_update === 1'b1) upd_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  // One-cycle low on fsync_in; returns at the negedge right after the edge is processed.
  task automatic do_frame();
    @(negedge clk);
    fsync_in = 1'b0;
    @(negedge clk);
    fsync_in = 1'b1;
  endtask

  // Raise a request, return at the negedge after it is sampled with sel_req dropped.
  task automatic request(input logic [2:0] p);
    @(negedge clk);
    sel_req     = 1'b1;
    sel_pattern = p;
    @(negedge clk);
    sel_req = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_psel"},  32'(pattern_sel),    32'd0);
    chk({tag, "_cnt"},   32'(frame_cnt),      32'd0);
    chk({tag, "_upd"},   32'(pattern_update), 32'd0);
    chk({tag, "_ack"},   32'(sel_ack),        32'd0);
    chk({tag, "_busy"},  32'(busy),           32'd0);
    chk({tag, "_auto"},  32'(auto_mode),      32'd1);
    chk({tag, "_state"}, 32'(state_dbg),      32'(ST_SYNC));
  endtask

  logic [2:0] exp_psel [13];
  logic [7:0] exp_cnt  [13];

  initial begin
    n_cmp = 0; n_err = 0; upd_cnt = 0;
    rst_n = 1'b0; fsync_in = 1'b1; sel_req = 1'b0; sel_pattern = 3'd0; resume = 1'b0;
    exp_psel = '{3'd0, 3'd0, 3'd0, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd3, 3'd3, 3'd3, 3'd0};
    exp_cnt  = '{8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0, 8'd1, 8'd2, 8'd0};

    // Reset values
    idle(3);
    chk_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    idle(2);

    // Auto sequence: 13 frame edges
    upd_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      do_frame();
      chk($sformatf("auto_psel_%0d", i), 32'(pattern_sel), 32'(exp_psel[i]));
      chk($sformatf("auto_cnt_%0d", i),  32'(frame_cnt),   32'(exp_cnt[i]));
      idle(3);
      chk($sformatf("auto_hold_%0d", i), 32'(pattern_sel), 32'(exp_psel[i]));
    end
    chk("auto_upd_count", 32'(upd_cnt), 32'd4);
    chk("auto_state", 32'(state_dbg), 32'(ST_AUTO));

    // Manual request for pattern 2 from AUTO (psel 0, cnt 0)
    request(3'd2);
    chk("req2_ack",  32'(sel_ack),   32'd1);
    chk("req2_busy", 32'(busy),      32'd1);
    chk("req2_auto", 32'(auto_mode), 32'd0);
    @(negedge clk);
    chk("req2_ack_one", 32'(sel_ack), 32'd0);
    chk("req2_psel_hold", 32'(pattern_sel), 32'd0);
    do_frame();
    chk("req2_psel", 32'(pattern_sel),    32'd2);
    chk("req2_upd",  32'(pattern_update), 32'd1);
    chk("req2_busy0", 32'(busy),          32'd0);
    chk("req2_cnt",  32'(frame_cnt),      32'd0);
    chk("req2_state", 32'(state_dbg),     32'(ST_MANUAL));

    // Out-of-range request clamps; second request while busy is ignored
    request(3'd6);
    chk("req6_ack", 32'(sel_ack), 32'd1);
    @(negedge clk);
    sel_req = 1'b1; sel_pattern = 3'd1;
    @(negedge clk);
    chk("busy_req_ack_a", 32'(sel_ack), 32'd0);
    @(negedge clk);
    chk("busy_req_ack_b", 32'(sel_ack), 32'd0);
    sel_req = 1'b0;
    do_frame();
    chk("req6_psel", 32'(pattern_sel),    32'd3);
    chk("req6_upd",  32'(pattern_update), 32'd1);

    // Manual saturation over 300 frames
    for (int i = 0; i < 200; i++) do_frame();
    chk("man_cnt_200", 32'(frame_cnt), 32'd200);
    for (int i = 0; i < 100; i++) do_frame();
    chk("man_cnt_sat",  32'(frame_cnt),   32'd255);
    chk("man_psel",     32'(pattern_sel), 32'd3);
    chk("man_auto",     32'(auto_mode),   32'd0);
    @(negedge clk);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    chk("resume_auto", 32'(auto_mode),   32'd1);
    chk("resume_cnt",  32'(frame_cnt),   32'd0);
    chk("resume_psel", 32'(pattern_sel), 32'd3);
    do_frame();
    do_frame();
    chk("resume_cnt2",  32'(frame_cnt),   32'd2);
    // resume in AUTO must be ignored
    @(negedge clk);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    chk("resume_ign_cnt",   32'(frame_cnt), 32'd2);
    chk("resume_ign_state", 32'(state_dbg), 32'(ST_AUTO));
    do_frame();
    chk("resume_adv_psel", 32'(pattern_sel),    32'd0);
    chk("resume_adv_upd",  32'(pattern_update), 32'd1);

    // Request coincident with the wrapping edge (reach psel 3, cnt 2 first)
    for (int i = 0; i < 11; i++) do_frame();
    chk("pre_wrap_psel", 32'(pattern_sel), 32'd3);
    chk("pre_wrap_cnt",  32'(frame_cnt),   32'd2);
    @(negedge clk);
    fsync_in = 1'b0; sel_req = 1'b1; sel_pattern = 3'd1;
    @(negedge clk);
    fsync_in = 1'b1; sel_req = 1'b0;
    chk("coin_psel", 32'(pattern_sel),    32'd0);
    chk("coin_upd",  32'(pattern_update), 32'd1);
    chk("coin_ack",  32'(sel_ack),        32'd1);
    chk("coin_busy", 32'(busy),           32'd1);
    do_frame();
    chk("coin_apply_psel", 32'(pattern_sel),    32'd1);
    chk("coin_apply_upd",  32'(pattern_update), 32'd1);
    chk("coin_apply_cnt",  32'(frame_cnt),      32'd0);

    // MANUAL: sel_req and resume together, request wins
    @(negedge clk);
    sel_req = 1'b1; sel_pattern = 3'd2; resume = 1'b1;
    @(negedge clk);
    sel_req = 1'b0; resume = 1'b0;
    chk("race_ack",  32'(sel_ack),   32'd1);
    chk("race_busy", 32'(busy),      32'd1);
    chk("race_auto", 32'(auto_mode), 32'd0);
    do_frame();
    chk("race_psel",  32'(pattern_sel), 32'd2);
    chk("race_state", 32'(state_dbg),   32'(ST_MANUAL));

    // Reset while PENDING discards the request
    request(3'd1);
    chk("prerst_busy", 32'(busy), 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    // Requests ignored in SYNC_WAIT
    @(negedge clk);
    sel_req = 1'b1; sel_pattern = 3'd3;
    @(negedge clk);
    chk("sync_req_ack", 32'(sel_ack), 32'd0);
    @(negedge clk);
    chk("sync_req_busy", 32'(busy), 32'd0);
    sel_req = 1'b0;
    do_frame();
    chk("post_rst_e1_psel",  32'(pattern_sel),    32'd0);
    chk("post_rst_e1_upd",   32'(pattern_update), 32'd0);
    chk("post_rst_e1_state", 32'(state_dbg),      32'(ST_AUTO));
    do_frame();
    chk("post_rst_e2_psel", 32'(pattern_sel), 32'd0);
    chk("post_rst_e2_cnt",  32'(frame_cnt),   32'd1);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
